// File: rtl/ml_mac_accel.sv
// ml_mac_accel: memory-mapped signed 16x16 dot-product coprocessor with a wrapping 32-bit accumulator.
// Define ML_MAC_IRQ_EN to add the irq output and the CTRL.IE bit.
module ml_mac_accel #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              busy,
`ifdef ML_MAC_IRQ_EN
  output logic              irq,
`endif
  output logic              done
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, vidx;
  logic [6:0] len_q, len_d;
  logic [31:0] acc_q, acc_d, result_q, result_d, rdata_d, resp_rdata_q;
  logic done_q, done_d, err_q, err_d, resp_valid_q;
  logic [15:0] a_q [DEPTH];
  logic [15:0] b_q [DEPTH];
  logic [ADDR_W-9:0] region;
  logic [5:0] off;
  logic in_rng, is_reg, wr, rd, run;
  logic sel_ctrl, sel_stat, sel_len, sel_res, sel_a, sel_b;
  logic start, clr, busy_wr;
  logic signed [15:0] a_v, b_v;
  logic signed [31:0] prod;
  logic unused_ok;
`ifdef ML_MAC_IRQ_EN
  logic ie_q, irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr & sel_ctrl) ie_q <= req_wdata[2];
      irq_q <= done_q & ie_q;
    end
  end
  assign irq = irq_q;
`endif
  assign region   = req_addr[ADDR_W-1:8];
  assign off      = req_addr[7:2];
  assign vidx     = off[IW-1:0];
  assign in_rng   = {1'b0, off} < 7'(DEPTH);
  assign is_reg   = region == '0;
  assign sel_ctrl = is_reg && off == 6'd0;
  assign sel_stat = is_reg && off == 6'd1;
  assign sel_len  = is_reg && off == 6'd2;
  assign sel_res  = is_reg && off == 6'd3;
  assign sel_a    = region == (ADDR_W-8)'(1) && in_rng;
  assign sel_b    = region == (ADDR_W-8)'(2) && in_rng;
  assign wr       = req_valid & req_we;
  assign rd       = req_valid & ~req_we;
  assign run      = state_q == RUN;
  assign start    = wr & sel_ctrl & req_wdata[0] & ~run;
  assign clr      = wr & sel_ctrl & req_wdata[1];
  assign busy_wr  = wr & run & (sel_len | sel_a | sel_b);
  assign a_v      = a_q[idx_q];
  assign b_v      = b_q[idx_q];
  assign prod     = 32'(a_v) * 32'(b_v);
  assign unused_ok = ^{req_addr[1:0], req_wdata[31:16]};
  assign rdata_d = sel_stat ? {29'b0, err_q, done_q, run} :
                   sel_len  ? {25'b0, len_q} :
                   sel_res  ? result_q :
                   sel_a    ? {{16{a_q[vidx][15]}}, a_q[vidx]} :
                   sel_b    ? {{16{b_q[vidx][15]}}, b_q[vidx]} :
`ifdef ML_MAC_IRQ_EN
                   sel_ctrl ? {29'b0, ie_q, 2'b0} :
`endif
                   32'b0;
  // CLR is folded into the defaults so a combined CLR+START sees it first.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    len_d    = (wr & sel_len & ~run) ? req_wdata[6:0] : len_q;
    done_d   = done_q & ~clr;
    err_d    = (err_q & ~clr) | busy_wr;
    case (state_q)
      IDLE: if (start) begin
        done_d = 1'b0;
        idx_d  = '0;
        acc_d  = '0;
        if (len_q == 7'd0) state_d = FIN;
        else if (len_q > 7'(DEPTH)) begin
          err_d   = 1'b1;
          acc_d   = result_q;
          state_d = FIN;
        end else state_d = RUN;
      end
      RUN: begin
        acc_d   = acc_q + prod;
        idx_d   = idx_q + 1'b1;
        state_d = (7'(idx_q) == len_q - 7'd1) ? FIN : RUN;
      end
      FIN: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      acc_q        <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      result_q     <= result_d;
      done_q       <= done_d;
      err_q        <= err_d;
      resp_valid_q <= req_valid;
      resp_rdata_q <= rd ? rdata_d : 32'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (wr & sel_a & ~run) a_q[vidx] <= req_wdata[15:0];
    if (wr & sel_b & ~run) b_q[vidx] <= req_wdata[15:0];
  end
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign busy       = run;
  assign done       = done_q;
endmodule

// File: tb/tb_ml_mac_accel.sv
// tb_ml_mac_accel: directed bus-level test of ml_mac_accel with hand-computed expectations.
module tb_ml_mac_accel;
  logic clk, rst_n, req_valid, req_we, resp_valid, busy, done;
  logic [11:0] req_addr;
  logic [31:0] req_wdata, resp_rdata, d;
  int checks, errors, cyc, bcnt;
`ifdef ML_MAC_IRQ_EN
  logic irq;
`endif
  ml_mac_accel #(.DEPTH(16), .ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .busy(busy),
`ifdef ML_MAC_IRQ_EN
    .irq(irq),
`endif
    .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = v;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    chk("wr_resp_valid", {31'b0, resp_valid}, 32'd1);
  endtask
  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_resp_valid", {31'b0, resp_valid}, 32'd1);
    v = resp_rdata;
  endtask
  // Called right after a START write returns; cyc counts cycles since the START write cycle.
  task automatic wait_done(output int c, output int b);
    c = 1; b = 0;
    while (!done && c < 60) begin
      b += int'(busy);
      @(negedge clk);
      c++;
    end
    chk("done_timeout", {31'b0, done}, 32'd1);
  endtask
  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
    rst_n = 1'b1;
    rd(12'h004, d); chk("rst_status", d, 32'd0);
    rd(12'h00C, d); chk("rst_result", d, 32'd0);
    rd(12'h008, d); chk("rst_len", d, 32'd0);
    @(negedge clk);
    chk("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wr(12'h100 + 12'(4 * i), 32'(i + 1));
      wr(12'h200 + 12'(4 * i), 32'(i + 5));
    end
    wr(12'h008, 32'd4);
    wr(12'h000, 32'd1);
    chk("t2_busy_now", {31'b0, busy}, 32'd1);
    wait_done(cyc, bcnt);
    chk("t2_done_latency", 32'(cyc), 32'd6);
    chk("t2_busy_cycles", 32'(bcnt), 32'd4);
    rd(12'h00C, d); chk("t2_result", d, 32'd70);
    rd(12'h004, d); chk("t2_status", d, 32'd2);
    rd(12'h008, d); chk("t2_len", d, 32'd4);
    wr(12'h100, 32'h0000_FFFF);
    wr(12'h200, 32'd3);
    wr(12'h008, 32'd1);
    wr(12'h000, 32'd1);
    wait_done(cyc, bcnt);
    chk("t3_done_latency", 32'(cyc), 32'd3);
    chk("t3_busy_cycles", 32'(bcnt), 32'd1);
    rd(12'h00C, d); chk("t3_result", d, 32'hFFFF_FFFD);
    rd(12'h100, d); chk("t3_a0_sext", d, 32'hFFFF_FFFF);
    rd(12'h200, d); chk("t3_b0", d, 32'd3);
    wr(12'h008, 32'd17);
    wr(12'h000, 32'd1);
    wait_done(cyc, bcnt);
    chk("t4_err_latency", 32'(cyc), 32'd2);
    chk("t4_err_busy", 32'(bcnt), 32'd0);
    rd(12'h004, d); chk("t4_err_status", d, 32'd6);
    rd(12'h00C, d); chk("t4_err_result", d, 32'hFFFF_FFFD);
    wr(12'h140, 32'd5);
    rd(12'h140, d); chk("t4_a_oob", d, 32'd0);
    rd(12'h300, d); chk("t4_unmapped", d, 32'd0);
    rd(12'h000, d); chk("t4_ctrl_read", d, 32'd0);
    wr(12'h000, 32'd2);
    rd(12'h004, d); chk("t4_clr_status", d, 32'd0);
    wr(12'h008, 32'd0);
    wr(12'h000, 32'd1);
    wait_done(cyc, bcnt);
    chk("t4_len0_latency", 32'(cyc), 32'd2);
    chk("t4_len0_busy", 32'(bcnt), 32'd0);
    rd(12'h00C, d); chk("t4_len0_result", d, 32'd0);
    rd(12'h004, d); chk("t4_len0_status", d, 32'd2);
    wr(12'h100, 32'd1);
    wr(12'h200, 32'd5);
    wr(12'h008, 32'd4);
    wr(12'h000, 32'd1);
    wr(12'h100, 32'd9);
    wr(12'h000, 32'd1);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_done_seen", {31'b0, done}, 32'd1);
    rd(12'h00C, d); chk("t5_result", d, 32'd70);
    rd(12'h004, d); chk("t5_status", d, 32'd6);
    rd(12'h100, d); chk("t5_a0_kept", d, 32'd1);
    bcnt = 0;
    repeat (10) begin
      @(negedge clk);
      bcnt += int'(busy);
    end
    chk("t5_no_rerun", 32'(bcnt), 32'd0);
    chk("t5_done_held", {31'b0, done}, 32'd1);
    wr(12'h000, 32'd2);
    for (int i = 0; i < 16; i++) begin
      wr(12'h100 + 12'(4 * i), 32'h7FFF);
      wr(12'h200 + 12'(4 * i), 32'h7FFF);
    end
    wr(12'h008, 32'd16);
    wr(12'h000, 32'd1);
    rd(12'h00C, d); chk("t6_result_in_run", d, 32'd70);
    rd(12'h004, d); chk("t6_status_in_run", d, 32'd1);
    wait_done(cyc, bcnt);
    // 16 * 0x3FFF0001 = 0x3_FFF0_0010, truncated to 32 bits
    rd(12'h00C, d); chk("t6_wrap_result", d, 32'hFFF0_0010);
    wr(12'h000, 32'd1);
    chk("t6_busy_before_rst", {31'b0, busy}, 32'd1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h004;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_resp", {31'b0, resp_valid}, 32'd0);
    chk("t6_rst_busy_done", {30'b0, busy, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(12'h00C, d); chk("t6_rst_result", d, 32'd0);
    rd(12'h004, d); chk("t6_rst_status", d, 32'd0);
    rd(12'h008, d); chk("t6_rst_len", d, 32'd0);
    wr(12'h008, 32'd1);
`ifdef ML_MAC_IRQ_EN
    wr(12'h000, 32'd5);
`else
    wr(12'h000, 32'd1);
`endif
    wait_done(cyc, bcnt);
    chk("t7_latency", 32'(cyc), 32'd3);
`ifdef ML_MAC_IRQ_EN
    chk("irq_low_at_done", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_high", {31'b0, irq}, 32'd1);
    rd(12'h000, d); chk("ctrl_ie_read", d, 32'd4);
    wr(12'h000, 32'd6);
    chk("irq_clr_done", {31'b0, done}, 32'd0);
    chk("irq_still_high", {31'b0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_dropped", {31'b0, irq}, 32'd0);
`endif
    rd(12'h00C, d); chk("t7_result", d, 32'h3FFF_0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
